// File: rtl/gpio_write_arbiter.sv
// Round-robin arbiter sharing the GPIO write port between the core store path (req0)
// and the debug/boot loader (req1). Drives each accepted GPIO write for a timed window.
//   state   | meaning
//   IDLE    | waiting for a request, gpio outputs at 0
//   DRIVE   | gpio_addr/gpio_data driven with latched values, hold counter running
//   RELEASE | gpio outputs back to 0, winner gets its one-cycle ready/err pulse
module gpio_write_arbiter #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] GPIO_ADDR   = ADDR_W'(32'h0000ABCD),
    parameter int                HOLD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              req1_err,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_data,
    output logic              busy,
    output logic              last_grant,
    output logic [15:0]       wr_count
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, RELEASE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   gpio_addr_q, gpio_addr_d;
    logic [DATA_W-1:0]   gpio_data_q, gpio_data_d;
    logic                ready0_q, ready0_d, ready1_q, ready1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic                busy_q, busy_d;
    logic                last_grant_q, last_grant_d;
    logic [15:0]         wr_count_q, wr_count_d;
    logic                win;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        last_grant_d = last_grant_q;
        wr_count_d   = wr_count_q;
        gpio_addr_d  = '0;
        gpio_data_d  = '0;
        ready0_d     = 1'b0;
        ready1_d     = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        // on a tie the requester that was not granted last goes next
        win = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    last_grant_d = win;
                    addr_d       = win ? req1_addr : req0_addr;
                    data_d       = win ? req1_data : req0_data;
                    if (addr_d == GPIO_ADDR) begin
                        state_d     = DRIVE;
                        cnt_d       = CNT_W'(HOLD_CYCLES - 1);
                        gpio_addr_d = addr_d;
                        gpio_data_d = data_d;
                    end else begin
                        state_d  = RELEASE;
                        ready0_d = ~win;
                        ready1_d = win;
                        err0_d   = ~win;
                        err1_d   = win;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d    = RELEASE;
                    ready0_d   = ~last_grant_q;
                    ready1_d   = last_grant_q;
                    wr_count_d = wr_count_q + 16'd1;
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    gpio_addr_d = addr_q;
                    gpio_data_d = data_q;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            gpio_addr_q  <= '0;
            gpio_data_q  <= '0;
            ready0_q     <= 1'b0;
            ready1_q     <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= 1'b1;
            wr_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            gpio_addr_q  <= gpio_addr_d;
            gpio_data_q  <= gpio_data_d;
            ready0_q     <= ready0_d;
            ready1_q     <= ready1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign req0_ready = ready0_q;
    assign req1_ready = ready1_q;
    assign req0_err   = err0_q;
    assign req1_err   = err1_q;
    assign gpio_addr  = gpio_addr_q;
    assign gpio_data  = gpio_data_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_gpio_write_arbiter.sv
// Scoreboard bench for gpio_write_arbiter: stimulus pushes expected completions,
// a negedge monitor pops them when a ready/err pulse appears.
module tb_gpio_write_arbiter;

    localparam logic [31:0] GA   = 32'h0000ABCD;
    localparam int          HOLD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req0_data, req1_addr, req1_data;
    logic        req0_ready, req0_err, req1_ready, req1_err;
    logic [31:0] gpio_addr, gpio_data;
    logic        busy, last_grant;
    logic [15:0] wr_count;

    gpio_write_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
        .req0_ready(req0_ready), .req0_err(req0_err),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
        .req1_ready(req1_ready), .req1_err(req1_err),
        .gpio_addr(gpio_addr), .gpio_data(gpio_data),
        .busy(busy), .last_grant(last_grant), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          idx;
        bit          err;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          drv_cnt = 0;
    bit          drv_change = 0;
    logic [31:0] cap_a, cap_d;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input bit idx, input bit err, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.idx = idx; e.err = err; e.a = a; e.d = d;
        sb.push_back(e);
    endtask

    // monitor: tracks each drive window and checks it on the matching ready pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (gpio_addr != 0 || gpio_data != 0) begin
                if (drv_cnt == 0) begin
                    cap_a = gpio_addr;
                    cap_d = gpio_data;
                end else if (gpio_addr != cap_a || gpio_data != cap_d) begin
                    drv_change = 1;
                end
                drv_cnt++;
            end
            if (req0_ready || req1_ready || req0_err || req1_err) begin
                chk("both_ready", {62'd0, req0_ready, req1_ready} == 64'd3, 0);
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_idx", {req1_ready, req0_ready}, e.idx ? 2'b10 : 2'b01);
                    chk("err", {req1_err, req0_err}, e.err ? (e.idx ? 2'b10 : 2'b01) : 2'b00);
                    chk("drive_cycles", drv_cnt, e.err ? 0 : HOLD);
                    if (!e.err) begin
                        chk("gpio_addr", cap_a, e.a);
                        chk("gpio_data", cap_d, e.d);
                        chk("data_stable", drv_change, 0);
                    end
                end
                drv_cnt    = 0;
                drv_change = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        req0_valid = 0; req1_valid = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        drv_cnt = 0; drv_change = 0;
    endtask

    task automatic single(input bit idx, input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input bit chg);
        bit seen = 0;
        @(negedge clk);
        if (idx) begin req1_valid = 1; req1_addr = a; req1_data = d; end
        else     begin req0_valid = 1; req0_addr = a; req0_data = d; end
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_after_accept", busy, 1);
            if (chg && gpio_addr == GA) begin
                if (idx) req1_data = d ^ 32'hFF; else req0_data = d ^ 32'hFF;
            end
            if (idx ? req1_ready : req0_ready) begin
                seen = 1;
                chk("latency", k, exp_lat);
            end
        end
        if (!seen) chk("ready_timeout", 0, 1);
        req0_valid = 0; req1_valid = 0;
    endtask

    task automatic drive_both(input int n0, input logic [31:0] a0, input logic [31:0] d0,
                              input int n1, input logic [31:0] a1, input logic [31:0] d1);
        int c0 = 0, c1 = 0;
        @(negedge clk);
        req0_addr = a0; req0_data = d0; req0_valid = (n0 > 0);
        req1_addr = a1; req1_data = d1; req1_valid = (n1 > 0);
        for (int k = 0; k < 200 && (c0 < n0 || c1 < n1); k++) begin
            @(negedge clk);
            if (req0_ready) begin
                c0++; req0_data = d0 + c0;
                if (c0 >= n0) req0_valid = 0;
            end
            if (req1_ready) begin
                c1++; req1_data = d1 + c1;
                if (c1 >= n1) req1_valid = 0;
            end
        end
        chk("both_done", c0 + c1, n0 + n1);
        req0_valid = 0; req1_valid = 0;
    endtask

    initial begin
        bit hit = 0;
        reset = 1;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        do_reset();
        @(negedge clk);
        chk("rst_gpio_addr", gpio_addr, 0);
        chk("rst_gpio_data", gpio_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_last_grant", last_grant, 1);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_ready", {req0_ready, req1_ready, req0_err, req1_err}, 0);

        // T1: lone good write from req0
        push(0, 0, GA, 32'd96);
        single(0, GA, 32'd96, HOLD + 1, 0);
        repeat (2) @(negedge clk);
        chk("t1_wr_count", wr_count, 1);
        chk("t1_idle", {busy, gpio_addr != 0}, 0);

        // T2: bad address from req1
        push(1, 1, 32'd16, 32'd96);
        single(1, 32'd16, 32'd96, 1, 0);
        repeat (2) @(negedge clk);
        chk("t2_wr_count", wr_count, 1);
        chk("t2_last_grant", last_grant, 1);

        // T3: tie after reset, req0 first
        do_reset();
        push(0, 0, GA, 32'd5);
        push(1, 0, GA, 32'd7);
        drive_both(1, GA, 32'd5, 1, GA, 32'd7);
        repeat (2) @(negedge clk);
        chk("t3_last_grant", last_grant, 1);
        chk("t3_wr_count", wr_count, 2);

        // T4: continuous contention alternates 0,1,0,1
        push(0, 0, GA, 32'd10); push(1, 0, GA, 32'd20);
        push(0, 0, GA, 32'd11); push(1, 0, GA, 32'd21);
        drive_both(2, GA, 32'd10, 2, GA, 32'd20);
        repeat (2) @(negedge clk);
        chk("t4_wr_count", wr_count, 6);

        // mixed: req0 bad address wins the tie, req1 good write follows
        push(0, 1, 32'h1234, 32'h33);
        push(1, 0, GA, 32'h44);
        drive_both(1, 32'h1234, 32'h33, 1, GA, 32'h44);
        repeat (2) @(negedge clk);
        chk("mix_wr_count", wr_count, 7);
        chk("mix_last_grant", last_grant, 1);

        // T5: reset during DRIVE aborts the write
        @(negedge clk);
        req0_valid = 1; req0_addr = GA; req0_data = 32'hBEEF;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (gpio_addr == GA) hit = 1;
        end
        chk("t5_drive_seen", hit, 1);
        reset = 1; req0_valid = 0;
        @(negedge clk);
        chk("t5_gpio_addr", gpio_addr, 0);
        chk("t5_ready", {req0_ready, req1_ready}, 0);
        chk("t5_wr_count", wr_count, 0);
        chk("t5_busy", busy, 0);
        reset = 0;
        drv_cnt = 0; drv_change = 0;
        repeat (3) @(negedge clk);
        chk("t5_no_late_ready", {req0_ready, req1_ready}, 0);

        // T6: wr_count wrap, data change during DRIVE ignored
        force dut.wr_count_q = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.wr_count_q;
        @(negedge clk);
        chk("t6_preload", wr_count, 16'hFFFF);
        push(0, 0, GA, 32'h55);
        single(0, GA, 32'h55, HOLD + 1, 1);
        repeat (2) @(negedge clk);
        chk("t6_wrap", wr_count, 0);

        for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule
